// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, reads the combinational imem, buffers words in a small queue for decode.
// One cycle from address to queue head; a full queue without a pop, or a stall, holds the PC.
module fetch_sequencer #(
    parameter int unsigned          ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter int unsigned          MEM_BYTES = 124,
    parameter int unsigned          QDEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic              fetch_fault,
    output logic [31:0]       fetch_count
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } q_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    // End address is formed one bit wider so a PC near the top of the space cannot wrap into range.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] end_addr;
        end_addr = {1'b0, a} + (ADDR_W + 1)'(4);
        return (a[1:0] == 2'b00) && (end_addr <= (ADDR_W + 1)'(MEM_BYTES));
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    q_entry_t          q_mem_q [QDEPTH];
    q_entry_t          q_mem_d [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic     pc_legal;
    logic     q_full;
    logic     q_nonempty;
    logic     do_fetch;
    logic     do_pop;
    q_entry_t head;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        q_mem_d       = q_mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        do_fetch      = 1'b0;
        do_pop        = 1'b0;

        pc_legal   = addr_legal(pc_q);
        q_full     = (count_q == CNT_W'(QDEPTH));
        q_nonempty = (count_q != '0);

        if (redirect_valid) begin
            // Flush drops everything, including a head that decode is accepting this cycle.
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = addr_legal(redirect_pc) ? ST_RUN : ST_FAULT;
        end else begin
            do_pop = q_nonempty && out_ready;

            if (state_q == ST_RUN) begin
                if (!pc_legal) begin
                    state_d = ST_FAULT;
                end else if (!stall && (!q_full || do_pop)) begin
                    do_fetch = 1'b1;
                end
            end

            if (do_fetch) begin
                q_mem_d[wr_ptr_q] = '{pc: pc_q, instr: imem_rdata};
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
                pc_d              = pc_q + ADDR_W'(4);
                fetch_count_d     = fetch_count_q + 32'd1;
            end

            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({do_fetch, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            q_mem_q       <= q_mem_d;
        end
    end

    // Head is read straight from queue storage, so imem_rdata never reaches out_* in the same cycle.
    assign head        = q_mem_q[rd_ptr_q];
    assign out_valid   = (count_q != '0);
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;
    assign imem_addr   = pc_q;
    assign fetch_fault = (state_q == ST_FAULT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte-array imem model, scoreboard of expected decode hand-offs.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_pc_q [$];
    logic [31:0] exp_ins_q [$];
    logic [7:0]  mem_b [0:127];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W   (64),
        .RESET_PC (64'h0),
        .MEM_BYTES(124),
        .QDEPTH   (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    function automatic logic [31:0] word_at(input int a);
        case (a)
            'h00:    return 32'h0040_0293;
            'h04:    return 32'h0000_0313;
            'h08:    return 32'h00A0_0693;
            'h28:    return 32'hFE00_04E3;
            'h2C:    return 32'h0010_0313;
            default: return 32'h0000_0013 | (32'(a) << 20);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            automatic logic [31:0] w = word_at(4 * i);
            mem_b[4*i]     = w[7:0];
            mem_b[4*i + 1] = w[15:8];
            mem_b[4*i + 2] = w[23:16];
            mem_b[4*i + 3] = w[31:24];
        end
    end

    // Combinational little-endian read; anything past the last whole word returns a marker.
    always_comb begin
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_addr < 64'd121) begin
            imem_rdata = {mem_b[imem_addr[6:0] + 7'd3], mem_b[imem_addr[6:0] + 7'd2],
                          mem_b[imem_addr[6:0] + 7'd1], mem_b[imem_addr[6:0]]};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_pc_q.push_back(start + 64'(4 * i));
            exp_ins_q.push_back(word_at(int'(start) + 4 * i));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_pc"}, out_pc, 64'd0);
        chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
        chk({tag, "_fetch_fault"}, 64'(fetch_fault), 64'd0);
        chk({tag, "_fetch_count"}, 64'(fetch_count), 64'd0);
        chk({tag, "_imem_addr"}, imem_addr, 64'd0);
    endtask

    // Every accepted head must match the oldest expected entry; an unexpected hand-off compares against all-ones.
    always @(negedge clk) begin : monitor
        logic [63:0] ep;
        logic [31:0] ei;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && redirect_valid === 1'b0) begin
            if (exp_pc_q.size() > 0) begin
                ep = exp_pc_q.pop_front();
                ei = exp_ins_q.pop_front();
            end else begin
                ep = '1;
                ei = '1;
            end
            chk("sb_pc", out_pc, ep);
            chk("sb_instr", 64'(out_instr), 64'(ei));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        out_ready      = 1'b0;
        tick();
        tick();
        chk_reset_outputs("rst");

        // Streaming with decode always ready
        out_ready = 1'b1;
        push_seq(64'h0, 2);
        reset_n = 1'b1;
        tick();
        chk("t1_first_valid", 64'(out_valid), 64'd1);
        chk("t1_first_pc", out_pc, 64'h0);
        chk("t1_first_instr", 64'(out_instr), 64'h0040_0293);
        tick();
        chk("t1_pc4", out_pc, 64'h4);
        chk("t1_instr4", 64'(out_instr), 64'h0000_0313);
        tick();
        chk("t1_valid8", 64'(out_valid), 64'd1);
        chk("t1_pc8", out_pc, 64'h8);
        chk("t1_instr8", 64'(out_instr), 64'h00A0_0693);
        reset_n   = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("t1_sb_empty", 64'(exp_pc_q.size()), 64'd0);

        // Backpressure from reset: queue fills with two entries and the PC stops
        reset_n = 1'b1;
        repeat (4) tick();
        chk("t2_fetch_count", 64'(fetch_count), 64'd2);
        chk("t2_imem_addr", imem_addr, 64'h8);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_head_pc", out_pc, 64'h0);
        push_seq(64'h0, 2);
        out_ready = 1'b1;
        tick();
        chk("t2_head4_valid", 64'(out_valid), 64'd1);
        chk("t2_head4_pc", out_pc, 64'h4);
        tick();
        chk("t2_head8_valid", 64'(out_valid), 64'd1);
        chk("t2_head8_pc", out_pc, 64'h8);

        // Redirect with two entries queued and a same-cycle pop
        redirect_valid = 1'b1;
        redirect_pc    = 64'h28;
        tick();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", 64'(out_valid), 64'd0);
        chk("t3_imem_addr", imem_addr, 64'h28);
        chk("t3_sb_empty", 64'(exp_pc_q.size()), 64'd0);
        push_seq(64'h28, 2);
        tick();
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_pc", out_pc, 64'h28);
        chk("t3_instr", 64'(out_instr), 64'hFE00_04E3);
        out_ready = 1'b0;
        tick();
        chk("t4_pre_count", 64'(fetch_count), 64'd6);
        chk("t4_pre_addr", imem_addr, 64'h30);

        // Stall for three cycles while the queue drains
        stall     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall_addr", imem_addr, 64'h30);
            chk("t4_stall_count", 64'(fetch_count), 64'd6);
        end
        chk("t4_drained", 64'(out_valid), 64'd0);
        chk("t4_sb_empty", 64'(exp_pc_q.size()), 64'd0);
        stall = 1'b0;
        tick();
        chk("t4_resume_valid", 64'(out_valid), 64'd1);
        chk("t4_resume_pc", out_pc, 64'h30);

        // Fault entry, a misaligned redirect that keeps the fault, and a legal one that clears it
        redirect_valid = 1'b1;
        redirect_pc    = 64'h7C;
        tick();
        redirect_valid = 1'b0;
        chk("t5_oob_fault", 64'(fetch_fault), 64'd1);
        chk("t5_oob_valid", 64'(out_valid), 64'd0);
        chk("t5_oob_addr", imem_addr, 64'h7C);
        tick();
        chk("t5_hold_fault", 64'(fetch_fault), 64'd1);
        chk("t5_hold_valid", 64'(out_valid), 64'd0);
        chk("t5_hold_count", 64'(fetch_count), 64'd7);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2A;
        tick();
        redirect_valid = 1'b0;
        chk("t5_misal_fault", 64'(fetch_fault), 64'd1);
        chk("t5_misal_valid", 64'(out_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2C;
        tick();
        redirect_valid = 1'b0;
        chk("t5_clear_fault", 64'(fetch_fault), 64'd0);
        chk("t5_clear_valid", 64'(out_valid), 64'd0);
        push_seq(64'h2C, 20);
        tick();
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_pc", out_pc, 64'h2C);
        chk("t5_instr", 64'(out_instr), 64'h0010_0313);

        // Run off the end of memory
        n = 0;
        while (fetch_fault !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("t6_end_fault", 64'(fetch_fault), 64'd1);
        chk("t6_end_valid", 64'(out_valid), 64'd0);
        chk("t6_end_addr", imem_addr, 64'h7C);
        chk("t6_end_count", 64'(fetch_count), 64'd27);
        chk("t6_sb_empty", 64'(exp_pc_q.size()), 64'd0);

        // One-cycle reset in the middle of a run
        push_seq(64'h0, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t6_restart_pc", out_pc, 64'h0);
        tick();
        chk("t6_pre_rst_count", 64'(fetch_count), 64'd29);
        reset_n = 1'b0;
        tick();
        chk_reset_outputs("t6_rst");
        reset_n = 1'b1;
        push_seq(64'h0, 1);
        tick();
        chk("t6_post_valid", 64'(out_valid), 64'd1);
        chk("t6_post_pc", out_pc, 64'h0);
        chk("t6_post_instr", 64'(out_instr), 64'h0040_0293);
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        tick();
        chk("final_sb_empty", 64'(exp_pc_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
